// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port sram between two picoRV-native masters.
// Round robin by default; define SRAM_ARB_FIXED_PRIO_EN for fixed m0-first priority.
module sram_arbiter #(
    parameter int ADDRWIDTH = 13
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 m0_valid,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_wdata,
    input  logic [3:0]           m0_wstrb,
    output logic                 m0_ready,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_valid,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_wdata,
    input  logic [3:0]           m1_wstrb,
    output logic                 m1_ready,
    output logic [31:0]          m1_rdata,
    output logic                 sram_select,
    output logic [3:0]           sram_wstrb,
    output logic [ADDRWIDTH-1:0] sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic                 sram_ready,
    input  logic [31:0]          sram_rdata,
    output logic                 owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic                   sram_select_q, sram_select_d;
    logic [3:0]             sram_wstrb_q, sram_wstrb_d;
    logic [ADDRWIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [31:0]            sram_wdata_q, sram_wdata_d;
    logic                   owner_q, owner_d;
    logic                   m0_ready_q, m0_ready_d;
    logic                   m1_ready_q, m1_ready_d;
    logic [31:0]            m0_rdata_q, m0_rdata_d;
    logic [31:0]            m1_rdata_q, m1_rdata_d;
    logic                   grant;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                   rr_last_q, rr_last_d;
`endif

    // Address bits above the sram range are ignored, so addresses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{m0_addr[31:ADDRWIDTH], m1_addr[31:ADDRWIDTH]};

    // Pick the winner among the masters requesting this cycle.
    always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        grant = ~m0_valid;
`else
        grant = (m0_valid && m1_valid) ? ~rr_last_q : m1_valid;
`endif
    end

    // Next-state and registered-output computation for the access sequence.
    always_comb begin
        state_d       = state_q;
        sram_select_d = sram_select_q;
        sram_wstrb_d  = sram_wstrb_q;
        sram_addr_d   = sram_addr_q;
        sram_wdata_d  = sram_wdata_q;
        owner_d       = owner_q;
        m0_ready_d    = m0_ready_q;
        m1_ready_d    = m1_ready_q;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        rr_last_d     = rr_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    sram_select_d = 1'b1;
                    owner_d       = grant;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    rr_last_d     = grant;
`endif
                    if (grant) begin
                        sram_addr_d  = m1_addr[ADDRWIDTH-1:0];
                        sram_wdata_d = m1_wdata;
                        sram_wstrb_d = m1_wstrb;
                    end else begin
                        sram_addr_d  = m0_addr[ADDRWIDTH-1:0];
                        sram_wdata_d = m0_wdata;
                        sram_wstrb_d = m0_wstrb;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // One-cycle select so a write lands exactly once.
                sram_select_d = 1'b0;
                state_d       = WAIT;
            end
            WAIT: begin
                if (sram_ready) begin
                    if (owner_q) begin
                        m1_rdata_d = sram_rdata;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = sram_rdata;
                        m0_ready_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                m0_ready_d = 1'b0;
                m1_ready_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sram_select_q <= 1'b0;
            sram_wstrb_q  <= '0;
            sram_addr_q   <= '0;
            sram_wdata_q  <= '0;
            owner_q       <= 1'b0;
            m0_ready_q    <= 1'b0;
            m1_ready_q    <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_last_q     <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            sram_select_q <= sram_select_d;
            sram_wstrb_q  <= sram_wstrb_d;
            sram_addr_q   <= sram_addr_d;
            sram_wdata_q  <= sram_wdata_d;
            owner_q       <= owner_d;
            m0_ready_q    <= m0_ready_d;
            m1_ready_q    <= m1_ready_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_last_q     <= rr_last_d;
`endif
        end
    end

    assign sram_select = sram_select_q;
    assign sram_wstrb  = sram_wstrb_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign owner       = owner_q;
    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed bench for sram_arbiter
// against a transaction-timeline reference model.
module tb_sram_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_valid, m1_valid;
    logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          sram_select;
    logic [3:0]    sram_wstrb;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic          sram_ready;
    logic [31:0]   sram_rdata;
    logic          owner;

    sram_arbiter #(.ADDRWIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .sram_select(sram_select), .sram_wstrb(sram_wstrb),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ready(sram_ready), .sram_rdata(sram_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // sram model: one-cycle-delayed ready, old data returned on writes
    logic [31:0] sram_mem [0:2047];
    logic        clr, pre_we;
    logic [10:0] pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2048; i++) sram_mem[i] <= '0;
            sram_ready <= 1'b0;
            sram_rdata <= '0;
        end else if (pre_we) begin
            sram_mem[pre_idx] <= pre_val;
        end else begin
            sram_ready <= sram_select;
            if (sram_select) begin
                sram_rdata <= sram_mem[sram_addr[12:2]];
                for (int b = 0; b < 4; b++)
                    if (sram_wstrb[b])
                        sram_mem[sram_addr[12:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    // reference model state
    logic [31:0] ref_mem [0:2047];
    int          cyc;
    bit          busy;
    int          g;
    bit          mo;
    bit          rr;
    logic [12:0] ra;
    logic [31:0] rw;
    logic [3:0]  rs;
    logic [31:0] er;
    logic [31:0] erd [2];
    int          pend [2];
    bit          gap, viol_en;
    bit          obs [$];
    int          n_vec, n_err;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int obs_at(int i);
        return (i < obs.size()) ? int'(obs[i]) : 2;
    endfunction

    task automatic req(bit m, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        if (!m) begin
            m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_valid = 1'b1;
        end else begin
            m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_valid = 1'b1;
        end
    endtask

    task automatic rand_req(bit m);
        logic [31:0] a;
        logic [3:0]  s;
        a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
        s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        req(m, a, $urandom, s);
    endtask

    task automatic model_reset();
        busy = 1'b0; rr = 1'b1; mo = 1'b0;
        erd[0] = '0; erd[1] = '0;
    endtask

    // one clock: model the edge, then check outputs and drive masters
    task automatic step();
        bit w, sel_e, r0_e, r1_e, v;
        @(posedge clk);
        cyc++;
        if (reset_n) begin
            if (busy && cyc == g + 4) busy = 1'b0;
            if (!busy && (m0_valid || m1_valid)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                w = !m0_valid;
`else
                w = (m0_valid && m1_valid) ? !rr : m1_valid;
                rr = w;
`endif
                mo = w; g = cyc; busy = 1'b1;
                ra = w ? m1_addr[12:0] : m0_addr[12:0];
                rw = w ? m1_wdata : m0_wdata;
                rs = w ? m1_wstrb : m0_wstrb;
                er = ref_mem[ra[12:2]];
                for (int b = 0; b < 4; b++)
                    if (rs[b]) ref_mem[ra[12:2]][8*b +: 8] = rw[8*b +: 8];
            end
        end
        @(negedge clk);
        sel_e = busy && cyc == g;
        r0_e  = busy && cyc == g + 2 && !mo;
        r1_e  = busy && cyc == g + 2 && mo;
        if (r0_e) erd[0] = er;
        if (r1_e) erd[1] = er;
        chk("select", 32'(sram_select), 32'(sel_e));
        if (sel_e) begin
            chk("sram_addr", 32'(sram_addr), 32'(ra));
            chk("sram_wdata", sram_wdata, rw);
            chk("sram_wstrb", 32'(sram_wstrb), 32'(rs));
        end
        chk("owner", 32'(owner), 32'(mo));
        chk("m0_ready", 32'(m0_ready), 32'(r0_e));
        chk("m1_ready", 32'(m1_ready), 32'(r1_e));
        chk("m0_rdata", m0_rdata, erd[0]);
        chk("m1_rdata", m1_rdata, erd[1]);
        if (m0_ready) obs.push_back(1'b0);
        if (m1_ready) obs.push_back(1'b1);
        if (r0_e) m0_valid = 1'b0;
        if (r1_e) m1_valid = 1'b0;
        if (viol_en && sel_e && $urandom_range(0, 7) == 0) begin
            if (mo) m1_valid = 1'b0;
            else    m0_valid = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            v = (m == 0) ? m0_valid : m1_valid;
            if (!v && pend[m] > 0 && !(busy && int'(mo) == m && cyc <= g + 2)
                && (!gap || $urandom_range(0, 1) == 1)) begin
                rand_req(m[0]);
                pend[m]--;
            end
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_sel"}, 32'(sram_select), 0);
        chk({tag, "_wstrb"}, 32'(sram_wstrb), 0);
        chk({tag, "_addr"}, 32'(sram_addr), 0);
        chk({tag, "_wdata"}, sram_wdata, 0);
        chk({tag, "_owner"}, 32'(owner), 0);
        chk({tag, "_rdy"}, 32'({m0_ready, m1_ready}), 0);
        chk({tag, "_rd0"}, m0_rdata, 0);
        chk({tag, "_rd1"}, m1_rdata, 0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_id;
        n_vec = 0; n_err = 0; cyc = 0; g = 0;
        gap = 1'b0; viol_en = 1'b0;
        pend[0] = 0; pend[1] = 0;
        m0_valid = 0; m1_valid = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_wstrb = 0; m1_wstrb = 0;
        pre_we = 0; pre_idx = 0; pre_val = 0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        model_reset();
        reset_n = 1'b0;
        clr = 1'b1;
        #1;
        chk_all_zero("rst");
        step();
        clr = 1'b0;
        pre_we = 1'b1; pre_idx = 11'h010; pre_val = 32'hCAFE_F00D;
        ref_mem[16] = 32'hCAFE_F00D;
        step();
        pre_we = 1'b0;
        reset_n = 1'b1;

        // single read by m0
        req(1'b0, 32'h0000_0040, 32'h0, 4'b0000);
        repeat (3) step();
        chk("t1_ready", 32'(m0_ready), 1);
        chk("t1_rdata", m0_rdata, 32'hCAFE_F00D);
        chk("t1_m1rdy", 32'(m1_ready), 0);
        repeat (2) step();

        // byte write then read by m1
        req(1'b1, 32'h0000_0044, 32'h0000_AB00, 4'b0010);
        repeat (5) step();
        req(1'b1, 32'h0000_0044, 32'h0, 4'b0000);
        repeat (3) step();
        chk("t2_rdata", m1_rdata, 32'h0000_AB00);
        repeat (2) step();

        // tie right after reset
        apply_reset();
        obs.delete();
        req(1'b0, 32'h0000_0040, 32'h0, 4'b0000);
        req(1'b1, 32'h8000_0044, 32'h0, 4'b0000);
        repeat (8) step();
        chk("tie_cnt", obs.size(), 2);
        chk("tie_0", obs_at(0), 0);
        chk("tie_1", obs_at(1), 1);

        // continuous contention, six each
        obs.delete();
        pend[0] = 6; pend[1] = 6;
        repeat (60) step();
        chk("cont_cnt", obs.size(), 12);
        for (int i = 0; i < 12; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            exp_id = (i < 6) ? 0 : 1;
`else
            exp_id = i % 2;
`endif
            chk($sformatf("cont_%0d", i), obs_at(i), exp_id);
        end
        repeat (2) step();

        // reset during WAIT; held m0 request re-served afterwards
        req(1'b0, 32'h1234_0040, 32'h0, 4'b0000);
        repeat (2) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("amid");
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("rst_ready", 32'(m0_ready), 1);
        chk("rst_rdata", m0_rdata, 32'hCAFE_F00D);
        repeat (2) step();

        // m1 drops valid during ISSUE
        obs.delete();
        req(1'b1, 32'h0000_0048, 32'h5A5A_5A5A, 4'b1111);
        step();
        m1_valid = 1'b0;
        repeat (5) step();
        chk("viol_cnt", obs.size(), 1);
        chk("viol_who", obs_at(0), 1);
        req(1'b0, 32'h0000_0048, 32'h0, 4'b0000);
        repeat (3) step();
        chk("viol_next", m0_rdata, 32'h5A5A_5A5A);
        repeat (2) step();

        // randomized traffic with gaps and occasional valid drops
        gap = 1'b1; viol_en = 1'b1;
        pend[0] = 20 + int'($urandom_range(0, 10));
        pend[1] = 20 + int'($urandom_range(0, 10));
        repeat (800) step();
        chk("drain", pend[0] + pend[1] + int'(m0_valid) + int'(m1_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master arbiter sharing one single-port sram instance between the picoRV CPU (m0) and a second bus master such as a DMA or UART loader (m1).
- Both masters use the picoRV native memory handshake: valid/ready, addr, wdata, wstrb, rdata.
- Drives the sram select/wstrb/addr/data port. Sequences the sram's one-cycle-delayed ready back to the winning master.
- Round-robin by default. Exactly one transaction is outstanding at a time.

Parameters:
- ADDRWIDTH, 13, width of sram_addr; passes m*_addr[ADDRWIDTH-1:0] to the sram unchanged (byte address).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_valid  in  1  CPU request, held until m0_ready
- m0_addr  in  32  CPU byte address
- m0_wdata  in  32  CPU write data
- m0_wstrb  in  4  CPU byte strobes, 0000 = read
- m0_ready  out  1  one-cycle completion pulse to CPU
- m0_rdata  out  32  read data, valid while m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same directions and widths as m0, for master 1
- sram_select  out  1  sram access strobe
- sram_wstrb  out  4  sram byte strobes
- sram_addr  out  ADDRWIDTH  sram byte address
- sram_wdata  out  32  sram write data
- sram_ready  in  1  sram ready, asserted the cycle after select
- sram_rdata  in  32  sram read data, valid with sram_ready
- owner  out  1  index of the master currently or last granted

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; rr_last=1, so m0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample m0_valid/m1_valid.
  - If any request is present, pick a winner and latch its addr[ADDRWIDTH-1:0], wdata and wstrb onto the sram_* outputs.
  - Set sram_select=1, set owner=winner, go to ISSUE.
  - Round robin: if both are valid, grant the master != rr_last; if one is valid, grant it.
  - rr_last updates to the winner on grant.
- ISSUE: sram_select=0 (select is high for exactly one cycle, so each write is performed exactly once); go to WAIT.
- WAIT: when sram_ready=1, latch sram_rdata into m[owner]_rdata, set m[owner]_ready=1, go to RESP.
  - The other master's ready stays 0 and its rdata holds.
- RESP: clear m[owner]_ready, go to IDLE.
  - The master drops valid on the edge where it sees ready, so IDLE never re-grants a completed request.
- Latency: valid sampled at edge N → sram_select high N..N+1 → sram_ready high N+1..N+2 → m_ready high N+2..N+3.
  - Three cycles from sample to ready. Back-to-back throughput is one transaction per 4 cycles.
- Writes: m_ready still pulses; m_rdata is updated with whatever sram_rdata shows (don't-care to the master).
- A master dropping valid mid-transaction (protocol violation): the transaction still completes and ready still pulses. A write already issued is not cancelled.
- Address bits above ADDRWIDTH are ignored; out-of-range addresses alias.
- A request arriving while the block is busy waits in its valid; there is no queue.
- Reset asserted mid-operation: immediately return to IDLE with all outputs 0.
  - An already-issued sram write may still land; sram contents are not reset.
  - After reset, a master still holding valid is re-served from scratch.
- sram_ready seen outside WAIT is ignored.

Optional Feature:
- Macro SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, m0 always wins when both are valid; rr_last logic is omitted. m1 may starve by design (CPU-first).
- Undefined: round robin as described above.

Test Plan:
- Single read, m0 only: mem word 0x10 preloaded with 0xCAFEF00D, m0 reads addr 0x40 with wstrb=0000.
  - sram_select high exactly 1 cycle with sram_addr=0x040.
  - m0_ready pulses 3 cycles after sampling, with m0_rdata=0xCAFEF00D.
  - m1_ready stays 0.
- Byte write then read, m1: write addr 0x44, wstrb=0010, wdata=0x0000AB00, then read 0x44.
  - Read returns 0x0000AB00 (starting from 0).
  - sram_select is high for one cycle per access.
- Tie after reset: m0 and m1 valid on the same cycle.
  - m0 is served first, then m1; owner goes 0 then 1.
  - Both served within 8 cycles.
- Continuous contention: both valid for 6 transactions each.
  - Grants alternate 0,1,0,1...
  - With SRAM_ARB_FIXED_PRIO_EN, all m0 transactions complete before any m1.
- Reset mid-transaction: deassert reset_n during WAIT.
  - All outputs 0 asynchronously.
  - After release, a held m0_valid completes normally with correct rdata.
- Valid drop violation: m1 drops valid in ISSUE.
  - m1_ready still pulses once.
  - The FSM returns to IDLE and the next request is served normally.
